// File: rtl/time_set_ctrl_if.sv
// Switch, strobe and time-value bundle between the time-setting controller
// and its surroundings (watch counters, LCD list block, board switches).
interface time_set_ctrl_if;
  logic       en_sample;
  logic       en_1hz;
  logic [3:0] sw_in;
  logic [1:0] cur_hour_10;
  logic [3:0] cur_hour_1;
  logic [2:0] cur_min_10;
  logic [3:0] cur_min_1;
  logic [1:0] set_hour_10;
  logic [3:0] set_hour_1;
  logic [2:0] set_min_10;
  logic [3:0] set_min_1;
  logic       load;
  logic       run_en;
  logic [1:0] blink_mask;
  logic [1:0] edit_field;

  modport master (
    output en_sample, en_1hz, sw_in, cur_hour_10, cur_hour_1, cur_min_10, cur_min_1,
    input  set_hour_10, set_hour_1, set_min_10, set_min_1, load, run_en, blink_mask, edit_field
  );

  modport slave (
    input  en_sample, en_1hz, sw_in, cur_hour_10, cur_hour_1, cur_min_10, cur_min_1,
    output set_hour_10, set_hour_1, set_min_10, set_min_1, load, run_en, blink_mask, edit_field
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces mode/up/down/confirm switches and runs the
// RUN / EDIT_HOUR / EDIT_MIN / COMMIT machine that edits and loads a BCD time.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned TIMEOUT_S    = 15
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT_S + 1);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] EDIT_HOUR = 2'd1;
  localparam logic [1:0] EDIT_MIN  = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic [3:0]     deb_q, deb_d, press_q, press_d;
  logic [DBW-1:0] cnt_q [4];
  logic [DBW-1:0] cnt_d [4];
  logic [1:0]     state_q, state_d;
  logic [5:0]     hour_q, hour_d;
  logic [6:0]     min_q, min_d;
  logic [TOW-1:0] tmo_q, tmo_d;
  logic           phase_q, phase_d;

  function automatic logic [5:0] hour_step(input logic [5:0] h, input logic up);
    logic [1:0] t;
    logic [3:0] o;
    t = h[5:4];
    o = h[3:0];
    if (up) begin
      if (h == 6'h23)     hour_step = 6'h00;
      else if (o == 4'd9) hour_step = {t + 2'd1, 4'd0};
      else                hour_step = {t, o + 4'd1};
    end else begin
      if (h == 6'h00)     hour_step = 6'h23;
      else if (o == 4'd0) hour_step = {t - 2'd1, 4'd9};
      else                hour_step = {t, o - 4'd1};
    end
  endfunction

  function automatic logic [6:0] min_step(input logic [6:0] m, input logic up);
    logic [2:0] t;
    logic [3:0] o;
    t = m[6:4];
    o = m[3:0];
    if (up) begin
      if (m == 7'h59)     min_step = 7'h00;
      else if (o == 4'd9) min_step = {t + 3'd1, 4'd0};
      else                min_step = {t, o + 4'd1};
    end else begin
      if (m == 7'h00)     min_step = 7'h59;
      else if (o == 4'd0) min_step = {t - 3'd1, 4'd9};
      else                min_step = {t, o - 4'd1};
    end
  endfunction

  // Press pulses are registered, so the FSM acts one cycle after the level settles.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.en_sample) begin
        if (bus.sw_in[i] != deb_q[i]) begin
          if (cnt_q[i] == DBW'(DEBOUNCE_CNT - 1)) begin
            deb_d[i]   = bus.sw_in[i];
            cnt_d[i]   = '0;
            press_d[i] = bus.sw_in[i];
          end else begin
            cnt_d[i] = cnt_q[i] + DBW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  logic any_press, pr_confirm, pr_mode, pr_up;
  assign any_press  = |press_q;
  assign pr_confirm = press_q[3];
  assign pr_mode    = press_q[0] & ~press_q[3];
  assign pr_up      = press_q[1] & ~press_q[3] & ~press_q[0];

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    tmo_d   = tmo_q;
    phase_d = phase_q;
    case (state_q)
      RUN: begin
        phase_d = 1'b0;
        tmo_d   = '0;
        if (pr_mode) begin
          hour_d  = {bus.cur_hour_10, bus.cur_hour_1};
          min_d   = {bus.cur_min_10, bus.cur_min_1};
          state_d = EDIT_HOUR;
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (bus.en_1hz) phase_d = ~phase_q;
        if (any_press) begin
          tmo_d = '0;
          if (pr_confirm)              state_d = COMMIT;
          else if (pr_mode)            state_d = (state_q == EDIT_HOUR) ? EDIT_MIN : EDIT_HOUR;
          else if (state_q == EDIT_HOUR) hour_d = hour_step(hour_q, pr_up);
          else                         min_d  = min_step(min_q, pr_up);
        end else if (bus.en_1hz) begin
          if (tmo_q == TOW'(TIMEOUT_S - 1)) begin
            state_d = RUN;
            tmo_d   = '0;
            phase_d = 1'b0;
          end else begin
            tmo_d = tmo_q + TOW'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q   <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q <= RUN;
      hour_q  <= '0;
      min_q   <= '0;
      tmo_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      tmo_q   <= tmo_d;
      phase_q <= phase_d;
    end
  end

  assign {bus.set_hour_10, bus.set_hour_1} = hour_q;
  assign {bus.set_min_10, bus.set_min_1}   = min_q;
  assign bus.load       = (state_q == COMMIT);
  assign bus.run_en     = (state_q == RUN);
  assign bus.edit_field = (state_q == EDIT_HOUR) ? 2'b01 :
                          (state_q == EDIT_MIN)  ? 2'b10 : 2'b00;
  assign bus.blink_mask = {phase_q & (state_q == EDIT_HOUR), phase_q & (state_q == EDIT_MIN)};
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: integer-valued hours/minutes model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_time_set_ctrl;
  localparam int DB  = 4;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  time_set_ctrl_if bus();

  time_set_ctrl #(.DEBOUNCE_CNT(DB), .TIMEOUT_S(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int loads  = 0;
  int cyc    = 0;

  function automatic logic [12:0] bcd(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  // Model: state 0=RUN 1=HOUR 2=MIN 3=COMMIT; time held as plain integers.
  int m_state, hr, mn, tmo, phase;
  int deb [4];
  int cnt [4];
  bit prs [4];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_state = 0; hr = 0; mn = 0; tmo = 0; phase = 0;
      for (int i = 0; i < 4; i++) begin deb[i] = 0; cnt[i] = 0; prs[i] = 0; end
    end else begin
      int act;
      act = -1;
      if (prs[3]) act = 3;
      else if (prs[0]) act = 0;
      else if (prs[1]) act = 1;
      else if (prs[2]) act = 2;
      case (m_state)
        0: if (act == 0) begin
             hr = bus.cur_hour_10 * 10 + bus.cur_hour_1;
             mn = bus.cur_min_10 * 10 + bus.cur_min_1;
             tmo = 0; phase = 0; m_state = 1;
           end
        1, 2: begin
          if (bus.en_1hz) phase = 1 - phase;
          if (act >= 0) begin
            tmo = 0;
            case (act)
              3: m_state = 3;
              0: m_state = 3 - m_state;
              1: if (m_state == 1) hr = (hr + 1) % 24; else mn = (mn + 1) % 60;
              default: if (m_state == 1) hr = (hr + 23) % 24; else mn = (mn + 59) % 60;
            endcase
          end else if (bus.en_1hz) begin
            tmo++;
            if (tmo == TMO) begin m_state = 0; tmo = 0; phase = 0; end
          end
        end
        default: m_state = 0;
      endcase
      for (int i = 0; i < 4; i++) begin
        prs[i] = 0;
        if (bus.en_sample) begin
          if (int'(bus.sw_in[i]) != deb[i]) begin
            cnt[i]++;
            if (cnt[i] == DB) begin
              deb[i] = bus.sw_in[i]; cnt[i] = 0; prs[i] = (deb[i] == 1);
            end
          end else cnt[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] got, expv;
    if (cyc > 0) begin
      got  = {bus.run_en, bus.load, bus.edit_field, bus.blink_mask,
              bus.set_hour_10, bus.set_hour_1, bus.set_min_10, bus.set_min_1};
      expv = {m_state == 0, m_state == 3,
              (m_state == 1) ? 2'b01 : (m_state == 2) ? 2'b10 : 2'b00,
              phase == 1 && m_state == 1, phase == 1 && m_state == 2, bcd(hr, mn)};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL cycle %0d outputs got %h expected %h", cyc, got, expv);
      end
      if (bus.load === 1'b1) loads++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input int n);
    repeat (n) begin @(negedge clk); bus.en_sample = 1'b1; @(negedge clk); bus.en_sample = 1'b0; end
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); bus.en_1hz = 1'b1; @(negedge clk); bus.en_1hz = 1'b0; end
  endtask
  task automatic hold(input logic [3:0] m, input int n);
    bus.sw_in = m; strobe(n);
  endtask
  task automatic press(input logic [3:0] m);
    hold(m, 6); bus.sw_in = '0; strobe(6); clocks(2);
  endtask
  task automatic setcur(input int h, input int m);
    {bus.cur_hour_10, bus.cur_hour_1, bus.cur_min_10, bus.cur_min_1} = bcd(h, m);
  endtask

  logic [12:0] set_now;
  assign set_now = {bus.set_hour_10, bus.set_hour_1, bus.set_min_10, bus.set_min_1};

  localparam logic [3:0] MODE = 4'b0001, UP = 4'b0010, DOWN = 4'b0100, CONF = 4'b1000;

  initial begin
    int l0;
    bus.en_sample = 1'b0; bus.en_1hz = 1'b0; bus.sw_in = '0;
    setcur(23, 59);
    clocks(3);
    rst = 1'b0;
    clocks(1);
    chk("reset_run_en", 32'(bus.run_en), 1);
    chk("reset_load", 32'(bus.load), 0);
    chk("reset_set", 32'(set_now), 0);
    chk("reset_mask_field", 32'({bus.blink_mask, bus.edit_field}), 0);

    // Snapshot, debounce filter, hour wrap up, minute wrap up, commit.
    press(MODE);
    chk("edit_hour_field", 32'(bus.edit_field), 32'b01);
    chk("edit_run_en", 32'(bus.run_en), 0);
    chk("snapshot", 32'(set_now), 32'(bcd(23, 59)));
    hold(UP, 2); bus.sw_in = '0; strobe(3); clocks(2);
    chk("short_glitch", 32'(set_now), 32'(bcd(23, 59)));
    hold(UP, 10); bus.sw_in = '0; strobe(6); clocks(2);
    chk("hour_wrap_up", 32'(set_now), 32'(bcd(0, 59)));
    press(MODE);
    chk("edit_min_field", 32'(bus.edit_field), 32'b10);
    press(UP);
    chk("min_wrap_up", 32'(set_now), 32'(bcd(0, 0)));
    l0 = loads;
    press(CONF);
    chk("one_load", 32'(loads - l0), 1);
    chk("commit_run_en", 32'(bus.run_en), 1);
    chk("commit_set", 32'(set_now), 32'(bcd(0, 0)));

    // BCD borrow/carry and hour wrap down.
    setcur(0, 10);
    press(MODE); press(DOWN);
    chk("hour_wrap_down", 32'(set_now), 32'(bcd(23, 10)));
    press(MODE); press(DOWN);
    chk("min_borrow", 32'(set_now), 32'(bcd(23, 9)));
    press(UP);
    chk("min_carry", 32'(set_now), 32'(bcd(23, 10)));
    press(CONF);

    // Timeout, restarted by a press at tick 14.
    setcur(0, 0);
    l0 = loads;
    press(MODE); press(MODE); press(DOWN);
    chk("min_wrap_down", 32'(set_now), 32'(bcd(0, 59)));
    tick(1);
    chk("blink_min", 32'(bus.blink_mask), 32'b01);
    tick(13);
    press(UP);
    chk("press_at_14", 32'(bus.edit_field), 32'b10);
    tick(14);
    chk("no_timeout_14", 32'(bus.run_en), 0);
    tick(1);
    chk("timeout_run", 32'({bus.run_en, bus.edit_field, bus.blink_mask}), 32'b10000);
    chk("timeout_no_load", 32'(loads - l0), 0);

    // Confirm beats mode; presses in RUN are ignored.
    setcur(12, 34);
    l0 = loads;
    press(MODE); press(MODE);
    press(MODE | CONF);
    chk("prio_commit", 32'(loads - l0), 1);
    chk("prio_field", 32'({bus.run_en, bus.edit_field}), 32'b100);
    press(UP); press(DOWN); press(CONF);
    chk("run_ignore_load", 32'(loads - l0), 1);
    chk("run_ignore_state", 32'({bus.run_en, bus.edit_field}), 32'b100);
    chk("run_ignore_set", 32'(set_now), 32'(bcd(12, 34)));

    // Reset mid-edit with blink active.
    setcur(5, 5);
    l0 = loads;
    press(MODE);
    tick(1);
    chk("blink_hour", 32'(bus.blink_mask), 32'b10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_edit", 32'({bus.run_en, bus.load, bus.edit_field, bus.blink_mask}), 32'b100000);
    chk("rst_mid_set", 32'(set_now), 0);
    clocks(3);
    chk("rst_no_load", 32'(loads - l0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
